// File: rtl/retire_stage_if.sv
// rtl/retire_stage_if.sv - ROB entry type and retire-stage port bundle
package retire_stage_pkg;
  localparam int XLEN   = 32;
  localparam int PR_W   = 6;
  localparam int AREG_W = 5;

  typedef struct packed {
    logic              completed;
    logic              precise_state_need;
    logic [XLEN-1:0]   target_pc;
    logic [PR_W-1:0]   Tnew;
    logic [PR_W-1:0]   Told;
    logic [AREG_W-1:0] dest_areg;
    logic              is_store;
    logic              halt;
  } ROB_ENTRY_PACKET;
endpackage

interface retire_stage_if #(
  parameter int NUM_AREG = 32,
  parameter int CNT_W    = 64
);
  import retire_stage_pkg::*;

  // Retire group from the ROB: slot 2 oldest, slot 0 youngest
  ROB_ENTRY_PACKET [2:0]                 retire_entry;
  logic                                  BPRecoverEN;
  logic [XLEN-1:0]                       recover_pc;
  logic [2:0]                            free_pr_valid;
  logic [2:0][PR_W-1:0]                  free_pr;
  logic [2:0]                            sq_retire;
  logic [NUM_AREG-1:0][PR_W-1:0]         archi_maptable;
  logic [CNT_W-1:0]                      retire_count;
  logic                                  halted;

  modport master (
    output retire_entry,
    input  BPRecoverEN, recover_pc, free_pr_valid, free_pr, sq_retire,
    input  archi_maptable, retire_count, halted
  );

  modport slave (
    input  retire_entry,
    output BPRecoverEN, recover_pc, free_pr_valid, free_pr, sq_retire,
    output archi_maptable, retire_count, halted
  );
endinterface

// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - in-order commit of a 3-wide ROB retire group
module retire_stage
  import retire_stage_pkg::*;
#(
  parameter int NUM_AREG = 32,
  parameter int CNT_W    = 64
) (
  input  logic          clock,
  input  logic          reset,
  retire_stage_if.slave rif
);

  logic [2:0]      commit;
  logic [1:0]      n_commit;
  logic            do_recover;
  logic            do_halt;
  logic [XLEN-1:0] rec_pc;
  logic            stop;

  // Walk the group oldest-first; the first non-completed slot, or a committing
  // halt/recovery slot, stops everything younger. A flush or halt blocks all.
  always_comb begin
    commit     = '0;
    n_commit   = '0;
    do_recover = 1'b0;
    do_halt    = 1'b0;
    rec_pc     = '0;
    stop       = rif.BPRecoverEN | rif.halted;
    for (int i = 2; i >= 0; i--) begin
      if (!stop) begin
        if (rif.retire_entry[i].completed) begin
          commit[i] = 1'b1;
          n_commit  = n_commit + 2'd1;
          if (rif.retire_entry[i].halt) begin
            // halt takes priority over a redirect in the same entry
            do_halt = 1'b1;
            stop    = 1'b1;
          end else if (rif.retire_entry[i].precise_state_need) begin
            do_recover = 1'b1;
            rec_pc     = rif.retire_entry[i].target_pc;
            stop       = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  // Register flush pulse and sticky halt; reset cancels any pending pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rif.BPRecoverEN <= 1'b0;
      rif.recover_pc  <= '0;
      rif.halted      <= 1'b0;
    end else begin
      rif.BPRecoverEN <= do_recover;
      rif.recover_pc  <= do_recover ? rec_pc : '0;
      rif.halted      <= rif.halted | do_halt;
    end
  end

  // Per-slot freelist returns and store releases for committed slots
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rif.free_pr_valid <= '0;
      rif.free_pr       <= '0;
      rif.sq_retire     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (commit[i] && (rif.retire_entry[i].dest_areg != '0)) begin
          rif.free_pr_valid[i] <= 1'b1;
          rif.free_pr[i]       <= rif.retire_entry[i].Told;
        end else begin
          rif.free_pr_valid[i] <= 1'b0;
          rif.free_pr[i]       <= '0;
        end
        rif.sq_retire[i] <= commit[i] & rif.retire_entry[i].is_store;
      end
    end
  end

  // Architectural map: writes applied oldest to youngest so the youngest wins;
  // entry 0 is hard-wired to its reset mapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < NUM_AREG; a++) begin
        rif.archi_maptable[a] <= PR_W'(a);
      end
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (commit[i] && (rif.retire_entry[i].dest_areg != '0)) begin
          rif.archi_maptable[rif.retire_entry[i].dest_areg] <= rif.retire_entry[i].Tnew;
        end
      end
    end
  end

  // Retired-instruction counter, wraps naturally at full width
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rif.retire_count <= '0;
    end else begin
      rif.retire_count <= rif.retire_count + CNT_W'(n_commit);
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// tb/tb_retire_stage.sv - randomized and directed checks of retire_stage against a reference model
module tb_retire_stage;
  import retire_stage_pkg::*;

  logic clock;
  logic reset;

  retire_stage_if #(.NUM_AREG(32), .CNT_W(64)) rif();

  retire_stage #(.NUM_AREG(32), .CNT_W(64)) dut (
    .clock(clock),
    .reset(reset),
    .rif  (rif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [PR_W-1:0] m_map [32];
  logic [63:0]     m_cnt;
  bit              m_halted;
  bit              m_bp;
  logic [31:0]     m_pc;
  logic [2:0]      m_fv;
  logic [2:0][PR_W-1:0] m_fp;
  logic [2:0]      m_sq;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] map_pack();
    logic [31:0][PR_W-1:0] p;
    for (int a = 0; a < 32; a++) p[a] = m_map[a];
    return 256'(p);
  endfunction

  function automatic ROB_ENTRY_PACKET mk(bit c, bit psn, logic [31:0] pc, int tn, int to,
                                          int ar, bit st, bit h);
    ROB_ENTRY_PACKET e;
    e.completed          = c;
    e.precise_state_need = psn;
    e.target_pc          = pc;
    e.Tnew               = PR_W'(tn);
    e.Told               = PR_W'(to);
    e.dest_areg          = AREG_W'(ar);
    e.is_store           = st;
    e.halt               = h;
    return e;
  endfunction

  function automatic ROB_ENTRY_PACKET rnd_entry();
    return mk($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom,
              $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31),
              $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 32; a++) m_map[a] = PR_W'(a);
    m_cnt = '0; m_halted = 0; m_bp = 0; m_pc = '0;
    m_fv = '0; m_fp = '0; m_sq = '0;
  endtask

  task automatic check_all(input string tag, input bit pc_check);
    check({tag, ".bp"},  256'(rif.BPRecoverEN),    256'(m_bp));
    if (pc_check) check({tag, ".pc"}, 256'(rif.recover_pc), 256'(m_pc));
    check({tag, ".fv"},  256'(rif.free_pr_valid),  256'(m_fv));
    check({tag, ".fp"},  256'(rif.free_pr),        256'(m_fp));
    check({tag, ".sq"},  256'(rif.sq_retire),      256'(m_sq));
    check({tag, ".map"}, 256'(rif.archi_maptable), map_pack());
    check({tag, ".cnt"}, 256'(rif.retire_count),   256'(m_cnt));
    check({tag, ".hlt"}, 256'(rif.halted),         256'(m_halted));
  endtask

  // Present one group for one clock, advance the model, compare after the edge.
  // Committed slots are the leading run of completed entries from the oldest,
  // cut short right after the first halt/redirect entry.
  task automatic step(input string tag, input ROB_ENTRY_PACKET [2:0] g);
    int n;
    ROB_ENTRY_PACKET e;
    rif.retire_entry = g;
    n = 0;
    if (!m_bp && !m_halted) begin
      while (n < 3 && g[2-n].completed) begin
        n++;
        if (g[3-n].halt || g[3-n].precise_state_need) break;
      end
    end
    m_fv = '0; m_fp = '0; m_sq = '0; m_bp = 0; m_pc = '0;
    for (int k = 0; k < n; k++) begin
      e = g[2-k];
      if (e.dest_areg != 0) begin
        m_map[e.dest_areg] = e.Tnew;
        m_fv[2-k] = 1'b1;
        m_fp[2-k] = e.Told;
      end
      if (e.is_store) m_sq[2-k] = 1'b1;
    end
    if (n > 0) begin
      e = g[3-n];
      if (e.halt) m_halted = 1;
      else if (e.precise_state_need) begin
        m_bp = 1;
        m_pc = e.target_pc;
      end
    end
    m_cnt = m_cnt + 64'(n);
    @(posedge clock);
    #1;
    check_all(tag, m_bp);
  endtask

  // Assert reset between edges, check outputs immediately, release before next edge
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag, 1'b1);
    rif.retire_entry = '0;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_all({tag, ".post"}, 1'b1);
  endtask

  ROB_ENTRY_PACKET [2:0] g;

  initial begin
    reset = 1'b1;
    rif.retire_entry = '0;
    model_reset();
    #12;
    check_all("reset", 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // three plain commits
    g[2] = mk(1, 0, 0, 40, 1, 5, 0, 0);
    g[1] = mk(1, 0, 0, 41, 2, 6, 0, 0);
    g[0] = mk(1, 0, 0, 42, 3, 7, 0, 0);
    step("three", g);
    check("three.map5", 256'(rif.archi_maptable[5]), 256'(40));
    check("three.map7", 256'(rif.archi_maptable[7]), 256'(42));
    check("three.fv",   256'(rif.free_pr_valid), 256'(3'b111));
    check("three.cnt",  256'(rif.retire_count), 256'(3));

    // hole in the group blocks younger slots
    g[2] = mk(1, 0, 0, 20, 9, 8, 0, 0);
    g[1] = mk(0, 0, 0, 21, 9, 9, 0, 0);
    g[0] = mk(1, 0, 0, 22, 9, 10, 0, 0);
    step("hole", g);
    check("hole.fv",  256'(rif.free_pr_valid), 256'(3'b100));
    check("hole.cnt", 256'(rif.retire_count), 256'(4));

    // redirect in slot 1
    g[2] = mk(1, 0, 0, 30, 4, 11, 0, 0);
    g[1] = mk(1, 1, 32'h1000, 31, 5, 12, 0, 0);
    g[0] = mk(1, 0, 0, 32, 6, 13, 0, 0);
    step("redir", g);
    check("redir.bp", 256'(rif.BPRecoverEN), 256'(1));
    check("redir.pc", 256'(rif.recover_pc), 256'(32'h1000));
    check("redir.cnt", 256'(rif.retire_count), 256'(6));
    g[2] = mk(1, 0, 0, 50, 7, 14, 0, 0);
    g[1] = mk(1, 0, 0, 51, 7, 15, 0, 0);
    g[0] = mk(1, 0, 0, 52, 7, 16, 0, 0);
    step("flushcyc", g);
    check("flushcyc.bp",  256'(rif.BPRecoverEN), 256'(0));
    check("flushcyc.cnt", 256'(rif.retire_count), 256'(6));

    // same areg written twice: youngest wins, both Told freed
    g[2] = mk(1, 0, 0, 10, 33, 3, 0, 0);
    g[1] = mk(1, 0, 0, 11, 34, 0, 0, 0);
    g[0] = mk(1, 0, 0, 12, 35, 3, 0, 0);
    step("waw", g);
    check("waw.map3", 256'(rif.archi_maptable[3]), 256'(12));
    check("waw.fv",   256'(rif.free_pr_valid), 256'(3'b101));
    check("waw.map0", 256'(rif.archi_maptable[0]), 256'(0));

    // redirect, then async reset while the pulse is high
    g[2] = mk(1, 1, 32'h2000, 1, 1, 1, 0, 0);
    g[1] = '0;
    g[0] = '0;
    step("redir2", g);
    async_reset("midrec");
    check("midrec.map9", 256'(rif.archi_maptable[9]), 256'(9));

    // halt with a store behind it
    g[2] = mk(1, 1, 32'h3000, 2, 2, 0, 1, 1);
    g[1] = mk(1, 0, 0, 3, 3, 4, 1, 0);
    g[0] = '0;
    step("halt", g);
    check("halt.hlt", 256'(rif.halted), 256'(1));
    check("halt.sq",  256'(rif.sq_retire), 256'(3'b100));
    check("halt.bp",  256'(rif.BPRecoverEN), 256'(0));
    g[2] = mk(1, 0, 0, 5, 5, 5, 1, 0);
    g[1] = mk(1, 0, 0, 6, 6, 6, 1, 0);
    g[0] = mk(1, 0, 0, 7, 7, 7, 1, 0);
    step("halted", g);
    check("halted.cnt", 256'(rif.retire_count), 256'(1));
    async_reset("hrst");

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < 3; s++) g[s] = rnd_entry();
      step("rnd", g);
      if ((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 59) == 0)
        async_reset("rrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
